platform_button_irq: RTL
========================

// Module: platform_button_irq
// PURPOSE
//  Parametrised Avalon-MM input PIO for push-buttons/switches: WIDTH channels, each
//  with a 2-FF synchroniser and a debouncer. Adds per-bit edge capture, an interrupt
//  mask and a level irq to the Nios II. Sits on the system interconnect as a slave.
// PARAMETERS
//  WIDTH            4           number of input channels (1..32)
//  DEBOUNCE_CYCLES  50000       consecutive stable clocks before a change is accepted; 0 = bypass
//  EDGE_MODE        0           0 rising, 1 falling, 2 both edges set edgecapture
//  RESET_VALUE      {WIDTH{1'b1}} reset value of sync/debounced state (buttons idle high)
// PORTS
//  clk        in   1      system clock
//  reset      in   1      asynchronous, active-high reset
//  address    in   2      word address of register
//  chipselect in   1      slave select
//  write_n    in   1      active-low write strobe (valid with chipselect)
//  writedata  in   32     write data
//  in_port    in   WIDTH  raw asynchronous button inputs
//  readdata   out  32     registered read data
//  irq        out  1      level interrupt request
// BEHAVIOUR
//  - Reset (async, active-high): sync FFs and debounced = RESET_VALUE; irqmask, edgecapture,
//    debounce counters, readdata = 0; irq = 0. No edge may be captured out of reset.
//  - Register map: 0 data (RO, debounced), 1 reserved (reads 0), 2 irqmask (RW, [WIDTH-1:0]),
//    3 edgecapture (read; write 1 clears bit). Bits >= WIDTH read 0, writes ignored.
//  - readdata updated every clock from address (mux registered): read latency 1 cycle.
//  - Synchroniser: 2 flops per bit; debouncer sees bit 2 cycles after in_port change.
//  - Debounce per channel: counter clears when sync == debounced; else increments;
//    on reaching DEBOUNCE_CYCLES-1 debounced <= sync, counter clears. A glitch shorter
//    than DEBOUNCE_CYCLES clocks never reaches debounced. Counter saturates, never wraps.
//  - Total latency raw->data register: 2 + DEBOUNCE_CYCLES clocks (2 if bypassed).
//  - Edge detect on debounced vs. its 1-cycle-delayed copy, per EDGE_MODE.
//  - edgecapture bit sets on detected edge, holds until cleared by write-1 to addr 3.
//    Same-cycle edge and write-1-clear on same bit: set wins (no event lost).
//  - Writes with chipselect=0 or write_n=1 have no effect; writes to 0/1 ignored.
//  - irq = |(edgecapture & irqmask), registered (1 cycle after capture/mask change).
//  - Reset asserted mid-debounce discards pending count; no edge reported on release.
// STRUCTURE
//  - Package platform_pio_pkg: register offsets (ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3),
//    EDGE_RISING/FALLING/BOTH constants, function for counter width clog2(DEBOUNCE_CYCLES+1).
//  - Sub-module platform_pio_debounce: one channel (sync + counter + debounced reg),
//    instantiated WIDTH times by generate. Top holds edge logic, registers, read mux, irq.
// TESTING
//  1 Reset: assert reset mid-run -> readdata=0, irq=0, data reg reads RESET_VALUE after release.
//  2 DEBOUNCE_CYCLES=8: in_port[0] 1->0 held 20 clocks -> data bit0=0 exactly 10 clocks
//    after change; 5-clock glitch -> data unchanged, edgecapture stays 0.
//  3 EDGE_MODE=1, irqmask=4'b0001, press ch0 -> edgecapture=1, irq=1 next clock;
//    write 0x1 to addr 3 -> edgecapture=0, irq=0 one clock later.
//  4 Mask: irqmask=0, press ch2 -> edgecapture=4'b0100, irq=0; write irqmask=0x4 -> irq=1.
//  5 Collision: new edge on ch1 in same cycle as write-1-clear of ch1 -> bit1 remains 1.
//  6 Reads: addr 1 -> 0; WIDTH=4, write 0xFFFFFFFF to addr 2 -> reads 0x0000000F; 1-cycle latency.

Source files
------------

// File: rtl/platform_pio_pkg.sv
// Shared constants for the button/switch PIO: register offsets, edge-mode
// encodings and the debounce counter width helper.
package platform_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_BOTH    = 2;

    // Counter must hold 0..DEBOUNCE_CYCLES; never narrower than one bit.
    function automatic int cnt_width(input int debounce_cycles);
        int w;
        w = $clog2(debounce_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/platform_pio_debounce.sv
// One input channel: 2-flop synchroniser followed by a stable-count debouncer.
// DEBOUNCE_CYCLES = 0 passes the synchronised bit straight through.
module platform_pio_debounce
    import platform_pio_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_VALUE     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic debounced
);

    logic sync_1;
    logic sync_2;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= RESET_VALUE;
            sync_2 <= RESET_VALUE;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk or posedge reset) begin
                if (reset) debounced <= RESET_VALUE;
                else       debounced <= sync_2;
            end
        end else begin : g_count
            localparam int CW = cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] count;

            // Accept the new level only after DEBOUNCE_CYCLES consecutive mismatching clocks.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    count     <= '0;
                    debounced <= RESET_VALUE;
                end else if (sync_2 == debounced) begin
                    count <= '0;
                end else if (count >= CNT_LAST) begin
                    count     <= '0;
                    debounced <= sync_2;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/platform_button_irq.sv
// Avalon-MM input PIO for push-buttons: per-channel debounce, edge capture,
// interrupt mask and a registered level irq.
module platform_button_irq
    import platform_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_MODE       = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] debounced_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [31:0]      read_mux;
    logic             wr_en;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_chan
            platform_pio_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_VALUE     (RESET_VALUE[i])
            ) u_debounce (
                .clk       (clk),
                .reset     (reset),
                .raw       (in_port[i]),
                .debounced (debounced[i])
            );
        end

        if (WIDTH < 32) begin : g_unused_wdata
            logic unused_wdata;
            assign unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

    assign wr_en    = chipselect & ~write_n;
    assign edge_clr = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        case (EDGE_MODE)
            EDGE_FALLING: edge_det = ~debounced & debounced_d;
            EDGE_BOTH:    edge_det = debounced ^ debounced_d;
            default:      edge_det = debounced & ~debounced_d;
        endcase
    end

    // NOTE: read_mux gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DATA: read_mux = 32'(debounced);
            ADDR_MASK: read_mux = 32'(irqmask);
            ADDR_EDGE: read_mux = 32'(edgecapture);
            default:   read_mux = '0;
        endcase
    end

    // debounced_d resets to the same value as debounced so release never looks like an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            debounced_d <= RESET_VALUE;
            irqmask     <= '0;
            edgecapture <= '0;
            readdata    <= '0;
            irq         <= 1'b0;
        end else begin
            debounced_d <= debounced;
            if (wr_en && address == ADDR_MASK)
                irqmask <= writedata[WIDTH-1:0];
            // Set is applied after clear so a coincident edge is never lost.
            edgecapture <= (edgecapture & ~edge_clr) | edge_det;
            readdata    <= read_mux;
            irq         <= |(edgecapture & irqmask);
        end
    end

endmodule
